// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch sequencer: load-use hold, registered PC redirect with
// three-stage wrong-path squash, and saturating branch statistics.
module branch_resolve_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [2:0]        ex_funct3,
    input  logic [4:0]        ex_rs1,
    input  logic [4:0]        ex_rs2,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              mem_memread,
    input  logic [4:0]        mem_rd,
    output logic [2:0]        cmp_funct3,
    input  logic              cmp_taken,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_redirect,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              stall_idex,
    output logic              bubble_exmem,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count,
    output logic [CNT_W-1:0]  hold_count
);

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGT = 3'b101;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state;

    logic br;
    logic haz;
    logic sup;
    logic hold_c;
    logic resolve_c;
    logic take_c;

    // Branch qualification, load-use detection and resolve decision.
    always_comb begin
        br        = ex_valid & ex_is_branch;
        haz       = mem_memread & (mem_rd != 5'd0) &
                    ((mem_rd == ex_rs1) | (mem_rd == ex_rs2));
        sup       = (ex_funct3 == F3_BEQ) | (ex_funct3 == F3_BLT) |
                    (ex_funct3 == F3_BGT);
        hold_c    = ~reset & (state == RUN) & br & haz;
        resolve_c = br & (((state == RUN) & ~haz) | (state == HOLD));
        take_c    = resolve_c & cmp_taken & sup;
    end

    assign cmp_funct3   = ex_funct3;
    assign stall_pc     = hold_c;
    assign stall_ifid   = hold_c;
    assign stall_idex   = hold_c;
    assign bubble_exmem = hold_c;

    // State, registered redirect/squash outputs and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc_sel      <= 1'b0;
            pc_redirect <= '0;
            flush_ifid  <= 1'b0;
            flush_idex  <= 1'b0;
            flush_exmem <= 1'b0;
            br_count    <= '0;
            taken_count <= '0;
            hold_count  <= '0;
        end else begin
            pc_sel      <= take_c;
            flush_ifid  <= take_c;
            flush_idex  <= take_c;
            flush_exmem <= take_c;

            if (take_c) begin
                pc_redirect <= ex_target;
            end
            if (resolve_c && (br_count != {CNT_W{1'b1}})) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (take_c && (taken_count != {CNT_W{1'b1}})) begin
                taken_count <= taken_count + CNT_W'(1);
            end
            if (hold_c && (hold_count != {CNT_W{1'b1}})) begin
                hold_count <= hold_count + CNT_W'(1);
            end

            case (state)
                RUN: begin
                    if (hold_c) begin
                        state <= HOLD;
                    end else if (take_c) begin
                        state <= REDIRECT;
                    end else begin
                        state <= RUN;
                    end
                end
                // Operand now comes from WB forwarding, so HOLD never repeats.
                HOLD:     state <= take_c ? REDIRECT : RUN;
                REDIRECT: state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: reset, taken/not-taken, load-use
// hold, wrong-path ignore during redirect, mid-sequence reset.
module tb_branch_resolve_ctrl;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic              ex_is_branch;
    logic [2:0]        ex_funct3;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [ADDR_W-1:0] ex_target;
    logic              mem_memread;
    logic [4:0]        mem_rd;
    logic [2:0]        cmp_funct3;
    logic              cmp_taken;
    logic              pc_sel;
    logic [ADDR_W-1:0] pc_redirect;
    logic              stall_pc;
    logic              stall_ifid;
    logic              stall_idex;
    logic              bubble_exmem;
    logic              flush_ifid;
    logic              flush_idex;
    logic              flush_exmem;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  taken_count;
    logic [CNT_W-1:0]  hold_count;

    int checks   = 0;
    int failures = 0;

    branch_resolve_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_target(ex_target),
        .mem_memread(mem_memread), .mem_rd(mem_rd), .cmp_funct3(cmp_funct3),
        .cmp_taken(cmp_taken), .pc_sel(pc_sel), .pc_redirect(pc_redirect),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .br_count(br_count), .taken_count(taken_count),
        .hold_count(hold_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_is_branch = 0; ex_funct3 = 3'b000; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_target = '0; mem_memread = 0; mem_rd = 5'd0; cmp_taken = 0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic tk, input logic [ADDR_W-1:0] tgt);
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = f3; ex_rs1 = 5'd1; ex_rs2 = 5'd2;
        ex_target = tgt; cmp_taken = tk;
    endtask

    task automatic do_reset();
        reset = 1; idle(); tick(); tick(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            ex_valid = 1'($urandom); ex_is_branch = 1'($urandom); ex_funct3 = 3'($urandom);
            ex_rs1 = 5'($urandom); ex_rs2 = ex_rs1; ex_target = {32'($urandom), 32'($urandom)};
            mem_memread = 1; mem_rd = ex_rs1 | 5'd1; ex_rs1 = mem_rd; cmp_taken = 1'($urandom);
            #1;
            checks++; if ({stall_pc, stall_ifid, stall_idex, bubble_exmem} !== 4'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0000", {stall_pc, stall_ifid, stall_idex, bubble_exmem}); end
            tick();
            checks++; if ({pc_sel, flush_ifid, flush_idex, flush_exmem} !== 4'b0) begin failures++; $display("FAIL reset_ctrl: got %b expected 0000", {pc_sel, flush_ifid, flush_idex, flush_exmem}); end
            checks++; if (pc_redirect !== 64'h0) begin failures++; $display("FAIL reset_redirect: got %0h expected 0", pc_redirect); end
            checks++; if ({br_count, taken_count, hold_count} !== 96'h0) begin failures++; $display("FAIL reset_counts: got %0h/%0h/%0h expected 0/0/0", br_count, taken_count, hold_count); end
            checks++; if (cmp_funct3 !== ex_funct3) begin failures++; $display("FAIL reset_funct3: got %b expected %b", cmp_funct3, ex_funct3); end
        end
        reset = 0; idle();
    endtask

    task automatic test_taken_beq();
        do_reset();
        branch(3'b000, 1'b1, 64'h100);
        #1;
        checks++; if (stall_pc !== 1'b0) begin failures++; $display("FAIL beq_nostall: got %b expected 0", stall_pc); end
        tick(); idle(); #1;
        checks++; if (pc_sel !== 1'b1) begin failures++; $display("FAIL beq_pc_sel: got %b expected 1", pc_sel); end
        checks++; if (pc_redirect !== 64'h100) begin failures++; $display("FAIL beq_target: got %0h expected 100", pc_redirect); end
        checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b111) begin failures++; $display("FAIL beq_flush: got %b expected 111", {flush_ifid, flush_idex, flush_exmem}); end
        checks++; if (br_count !== 32'd1 || taken_count !== 32'd1) begin failures++; $display("FAIL beq_counts: got br=%0d taken=%0d expected 1/1", br_count, taken_count); end
        tick();
        checks++; if ({pc_sel, flush_ifid, flush_idex, flush_exmem} !== 4'b0) begin failures++; $display("FAIL beq_one_cycle: got %b expected 0000", {pc_sel, flush_ifid, flush_idex, flush_exmem}); end
    endtask

    task automatic test_not_taken();
        do_reset();
        branch(3'b100, 1'b0, 64'h240);
        tick(); idle();
        checks++; if ({pc_sel, flush_ifid, flush_idex, flush_exmem} !== 4'b0) begin failures++; $display("FAIL blt_nt_ctrl: got %b expected 0000", {pc_sel, flush_ifid, flush_idex, flush_exmem}); end
        checks++; if (br_count !== 32'd1 || taken_count !== 32'd0) begin failures++; $display("FAIL blt_nt_counts: got br=%0d taken=%0d expected 1/0", br_count, taken_count); end
        // bgt taken follows the same redirect path
        branch(3'b101, 1'b1, 64'h3c0);
        tick(); idle();
        checks++; if (pc_sel !== 1'b1 || pc_redirect !== 64'h3c0) begin failures++; $display("FAIL bgt_taken: got sel=%b tgt=%0h expected 1/3c0", pc_sel, pc_redirect); end
        checks++; if (br_count !== 32'd2 || taken_count !== 32'd1) begin failures++; $display("FAIL bgt_counts: got br=%0d taken=%0d expected 2/1", br_count, taken_count); end
    endtask

    task automatic test_hazard();
        do_reset();
        // mem_rd=0 and non-load never hazard
        branch(3'b000, 1'b0, 64'h0); mem_memread = 1; mem_rd = 5'd0; ex_rs1 = 5'd0; #1;
        checks++; if (stall_pc !== 1'b0) begin failures++; $display("FAIL haz_x0: got %b expected 0", stall_pc); end
        mem_memread = 0; mem_rd = 5'd1; ex_rs1 = 5'd1; #1;
        checks++; if (stall_pc !== 1'b0) begin failures++; $display("FAIL haz_noload: got %b expected 0", stall_pc); end
        do_reset();
        branch(3'b000, 1'b0, 64'h480); mem_memread = 1; mem_rd = 5'd5; ex_rs2 = 5'd5; #1;
        checks++; if ({stall_pc, stall_ifid, stall_idex, bubble_exmem} !== 4'b1111) begin failures++; $display("FAIL haz_stall: got %b expected 1111", {stall_pc, stall_ifid, stall_idex, bubble_exmem}); end
        checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b0) begin failures++; $display("FAIL haz_noflush: got %b expected 000", {flush_ifid, flush_idex, flush_exmem}); end
        tick();
        // still hazard-looking inputs, but HOLD must not stall again
        checks++; if ({stall_pc, stall_ifid, stall_idex, bubble_exmem} !== 4'b0) begin failures++; $display("FAIL hold_nostall: got %b expected 0000", {stall_pc, stall_ifid, stall_idex, bubble_exmem}); end
        checks++; if (hold_count !== 32'd1 || br_count !== 32'd0) begin failures++; $display("FAIL hold_counts: got hold=%0d br=%0d expected 1/0", hold_count, br_count); end
        cmp_taken = 1; tick(); idle();
        checks++; if (pc_sel !== 1'b1 || pc_redirect !== 64'h480) begin failures++; $display("FAIL hold_redirect: got sel=%b tgt=%0h expected 1/480", pc_sel, pc_redirect); end
        checks++; if (br_count !== 32'd1 || taken_count !== 32'd1 || hold_count !== 32'd1) begin failures++; $display("FAIL hold_after: got br=%0d taken=%0d hold=%0d expected 1/1/1", br_count, taken_count, hold_count); end
        // rs1 match also hazards
        tick(); branch(3'b100, 1'b0, 64'h0); mem_memread = 1; mem_rd = 5'd1; #1;
        checks++; if (stall_pc !== 1'b1) begin failures++; $display("FAIL haz_rs1: got %b expected 1", stall_pc); end
        tick(); idle();
    endtask

    task automatic test_redirect_ignore();
        do_reset();
        branch(3'b000, 1'b1, 64'h100);
        tick();
        branch(3'b000, 1'b1, 64'h200); mem_memread = 1; mem_rd = 5'd2; #1;
        checks++; if (stall_pc !== 1'b0 || flush_ifid !== 1'b1) begin failures++; $display("FAIL redir_excl: got stall=%b flush=%b expected 0/1", stall_pc, flush_ifid); end
        tick(); idle();
        checks++; if (pc_sel !== 1'b0) begin failures++; $display("FAIL redir_ignored_sel: got %b expected 0", pc_sel); end
        checks++; if (br_count !== 32'd1 || taken_count !== 32'd1 || hold_count !== 32'd0) begin failures++; $display("FAIL redir_ignored_counts: got br=%0d taken=%0d hold=%0d expected 1/1/0", br_count, taken_count, hold_count); end
        checks++; if (pc_redirect !== 64'h100) begin failures++; $display("FAIL redir_target_kept: got %0h expected 100", pc_redirect); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        branch(3'b000, 1'b1, 64'h100);
        tick(); reset = 1; tick(); reset = 0; idle();
        checks++; if ({pc_sel, flush_ifid, flush_idex, flush_exmem} !== 4'b0 || pc_redirect !== 64'h0) begin failures++; $display("FAIL rst_redir: got %b tgt=%0h expected 0000/0", {pc_sel, flush_ifid, flush_idex, flush_exmem}, pc_redirect); end
        checks++; if (br_count !== 32'd0 || taken_count !== 32'd0) begin failures++; $display("FAIL rst_redir_counts: got br=%0d taken=%0d expected 0/0", br_count, taken_count); end
        branch(3'b000, 1'b1, 64'h500); mem_memread = 1; mem_rd = 5'd1;
        tick(); mem_memread = 0; reset = 1; tick(); reset = 0; idle(); #1;
        checks++; if ({pc_sel, stall_pc, flush_exmem} !== 3'b0 || hold_count !== 32'd0) begin failures++; $display("FAIL rst_hold: got %b hold=%0d expected 000/0", {pc_sel, stall_pc, flush_exmem}, hold_count); end
        tick();
        checks++; if (pc_sel !== 1'b0) begin failures++; $display("FAIL rst_hold_late: got %b expected 0", pc_sel); end
        branch(3'b010, 1'b1, 64'h600);
        tick(); idle();
        checks++; if (pc_sel !== 1'b0 || br_count !== 32'd1 || taken_count !== 32'd0) begin failures++; $display("FAIL unsup_f3: got sel=%b br=%0d taken=%0d expected 0/1/0", pc_sel, br_count, taken_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            branch(3'b101, 1'b0, 64'h0);
            tick();
        end
        branch(3'b100, 1'b1, 64'h700);
        tick(); idle();
        checks++; if (br_count !== 32'd4 || taken_count !== 32'd1 || pc_redirect !== 64'h700) begin failures++; $display("FAIL b2b: got br=%0d taken=%0d tgt=%0h expected 4/1/700", br_count, taken_count, pc_redirect); end
        ex_valid = 0; ex_is_branch = 1; cmp_taken = 1; tick(); tick();
        checks++; if (br_count !== 32'd4 || pc_sel !== 1'b0) begin failures++; $display("FAIL invalid_br: got br=%0d sel=%b expected 4/0", br_count, pc_sel); end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_taken_beq();
        test_not_taken();
        test_hazard();
        test_redirect_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
